unpool_2x2_stream: RTL and testbench

- Streaming 2x2 upsampler; the inverse of the 2x2 max-pool stage.
- Takes a 6-channel INT8 feature map of IN_WIDTH x IN_HEIGHT pixels and emits a 2*IN_WIDTH x 2*IN_HEIGHT map.
- Two modes: nearest-neighbour replication, or max-unpool using a per-channel 2-bit argmax index captured at pooling time.
- Sits on the decoder/reconstruction path; valid/ready handshakes on both sides because output rate is 4x input rate.

---
 rtl/unpool_2x2_stream.sv | 129 ++++++++++++
 tb/tb_unpool_2x2_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unpool_2x2_stream.sv
// Streaming 2x2 upsampler (inverse of the 2x2 max-pool). Each input pixel becomes a 2x2 output block.
// The block works in nearest-replicate mode or in argmax-driven max-unpool mode.
module unpool_2x2_stream #(
    parameter int IN_WIDTH    = 12,
    parameter int IN_HEIGHT   = 12,
    parameter int UNPOOL_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    input  logic [11:0] in_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic        out_last
);

    localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    phase_t        phase;
    logic          sub;
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;

    logic [47:0]   hold_data;
    logic [11:0]   hold_idx;
    logic [47:0]   lb_data [IN_WIDTH];
    logic [11:0]   lb_idx  [IN_WIDTH];

    logic          adv;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          load;
    logic [47:0]   src_data;
    logic [11:0]   src_idx;
    logic [1:0]    quad;
    logic [47:0]   next_data;

    // Keep the channel whose argmax matches this quadrant; replicate mode keeps every channel.
    function automatic logic [47:0] place(input logic [47:0] d, input logic [11:0] ix,
                                          input logic [1:0] q);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            if (UNPOOL_MODE == 0 || ix[2*k +: 2] == q) begin
                r[8*k +: 8] = d[8*k +: 8];
            end
        end
        return r;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = (phase == EVEN) && !sub && adv;
    assign accept   = in_ready && in_valid;
    assign col_last = (in_col == CW'(IN_WIDTH - 1));
    assign row_last = (in_row == RW'(IN_HEIGHT - 1));
    assign load     = adv && (accept || sub || phase == ODD);
    assign quad     = {phase == ODD, sub};

    // The even row's left copy comes straight from the input, its right copy from the hold register,
    // and the odd row replays the line buffer.
    always_comb begin
        src_data = in_data;
        src_idx  = in_idx;
        if (phase == ODD) begin
            src_data = lb_data[in_col];
            src_idx  = lb_idx[in_col];
        end else if (sub) begin
            src_data = hold_data;
            src_idx  = hold_idx;
        end
        next_data = place(src_data, src_idx, quad);
    end

    // Pixel storage is not reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data       <= in_data;
            hold_idx        <= in_idx;
            lb_data[in_col] <= in_data;
            lb_idx[in_col]  <= in_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= EVEN;
            sub       <= 1'b0;
            in_col    <= '0;
            in_row    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            if (!load) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                out_data  <= next_data;
                out_last  <= (phase == ODD) && sub && col_last && row_last;
                sub       <= !sub;
                if (sub) begin
                    if (col_last) begin
                        in_col <= '0;
                        if (phase == EVEN) begin
                            phase <= ODD;
                        end else begin
                            phase  <= EVEN;
                            in_row <= row_last ? '0 : in_row + RW'(1);
                        end
                    end else begin
                        in_col <= in_col + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_unpool_2x2_stream.sv
// Scoreboard bench for unpool_2x2_stream: a replicate-mode and a max-unpool-mode instance share one stimulus stream.
// The expected 2x2 blocks are queued on every accepted pixel and popped on every output transfer.
`timescale 1ns/1ps
module tb_unpool_2x2_stream;

    localparam int W = 12;
    localparam int H = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [47:0] in_data;
    logic [11:0] in_idx;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [47:0] out_data0, out_data1;
    logic        out_last0, out_last1;

    typedef struct packed {
        logic [47:0] e0;
        logic [47:0] e1;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    int          lasts  = 0;
    int          m_col  = 0;
    int          m_row  = 0;
    logic [47:0] m_lb_d [W];
    logic [11:0] m_lb_i [W];

    always #5 clk = ~clk;

    unpool_2x2_stream #(.IN_WIDTH(W), .IN_HEIGHT(H), .UNPOOL_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_idx(in_idx), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0));

    unpool_2x2_stream #(.IN_WIDTH(W), .IN_HEIGHT(H), .UNPOOL_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_idx(in_idx), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Quadrant q: 0=TL 1=TR 2=BL 3=BR; max-unpool zeroes every channel whose argmax points elsewhere.
    function automatic logic [47:0] expect_block(input logic [47:0] d, input logic [11:0] ix,
                                                 input logic [1:0] q, input bit max_unpool);
        logic [47:0] r;
        r = d;
        if (max_unpool) begin
            for (int k = 0; k < 6; k++) begin
                if (ix[2*k +: 2] != q) r[8*k +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

    function automatic exp_t make_exp(input logic [47:0] d, input logic [11:0] ix,
                                      input logic [1:0] q, input logic last);
        exp_t e;
        e.e0   = expect_block(d, ix, q, 1'b0);
        e.e1   = expect_block(d, ix, q, 1'b1);
        e.last = last;
        return e;
    endfunction

    task automatic push_pixel(input logic [47:0] d, input logic [11:0] ix);
        sb.push_back(make_exp(d, ix, 2'd0, 1'b0));
        sb.push_back(make_exp(d, ix, 2'd1, 1'b0));
        m_lb_d[m_col] = d;
        m_lb_i[m_col] = ix;
        if (m_col == W - 1) begin
            for (int c = 0; c < W; c++) begin
                sb.push_back(make_exp(m_lb_d[c], m_lb_i[c], 2'd2, 1'b0));
                sb.push_back(make_exp(m_lb_d[c], m_lb_i[c], 2'd3, (m_row == H - 1) && (c == W - 1)));
            end
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // One cycle: drive after the falling edge, then judge what the next rising edge will transfer.
    task automatic applyStimulus(input logic v, input logic [47:0] d, input logic [11:0] ix,
                                 input logic ordy, output bit accepted);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_idx    = ix;
        out_ready = ordy;
        #1;
        accepted = 1'b0;
        if (out_valid0 && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 64'(out_data0), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                checkOutput("data_nearest", 64'(out_data0), 64'(e.e0));
                checkOutput("data_maxunpool", 64'(out_data1), 64'(e.e1));
                checkOutput("valid_maxunpool", 64'(out_valid1), 64'd1);
                checkOutput("last_nearest", 64'(out_last0), 64'(e.last));
                checkOutput("last_maxunpool", 64'(out_last1), 64'(e.last));
                popped++;
                if (out_last0) lasts++;
            end
        end
        if (in_valid && in_ready0) begin
            checkOutput("in_ready_maxunpool", 64'(in_ready1), 64'd1);
            push_pixel(d, ix);
            accepted = 1'b1;
        end
    endtask

    // kind 0: ramp ch0=12r+c, others -ch0; 1: all 5, idx 3; 2: all 7, idx k mod 4; 3: -128/127 checker.
    task automatic make_pixel(input int kind, input int r, input int c,
                              output logic [47:0] d, output logic [11:0] ix);
        logic [7:0] v;
        ix = 12'($urandom);
        case (kind)
            0: begin
                v = 8'(12 * r + c);
                d = {{5{8'(-v)}}, v};
            end
            1: begin
                d  = {6{8'd5}};
                ix = 12'hFFF;
            end
            2: begin
                d  = {6{8'd7}};
                ix = {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
            end
            default: d = ((r + c) % 2 == 0) ? {6{8'h80}} : {6{8'h7F}};
        endcase
    endtask

    function automatic logic pick_ready(input bit random_ready);
        return random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic run_frame(input int kind, input bit random_ready, input bit bp_hold, input int abort_after);
        logic [47:0] d;
        logic [11:0] ix;
        logic [47:0] held;
        bit          acc;
        int          guard;
        int          n;
        popped = 0;
        lasts  = 0;
        n      = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (abort_after >= 0 && n == abort_after) return;
                make_pixel(kind, r, c, d, ix);
                guard = 0;
                acc   = 1'b0;
                while (!acc && guard < 200) begin
                    applyStimulus(1'b1, d, ix, pick_ready(random_ready), acc);
                    guard++;
                end
                if (!acc) checkOutput("accept_timeout", 64'(guard), 64'd0);
                n++;
                if (bp_hold && n == 6) begin
                    applyStimulus(1'b0, '0, '0, 1'b0, acc);
                    held = out_data0;
                    checkOutput("bp_valid", 64'(out_valid0), 64'd1);
                    for (int i = 0; i < 4; i++) begin
                        applyStimulus(1'b0, '0, '0, 1'b0, acc);
                        checkOutput("bp_data_stable", 64'(out_data0), 64'(held));
                        checkOutput("bp_in_ready", 64'(in_ready0), 64'd0);
                    end
                end
            end
        end
        guard = 0;
        while (sb.size() != 0 && guard < 3000) begin
            applyStimulus(1'b0, '0, '0, pick_ready(random_ready), acc);
            guard++;
        end
        checkOutput("frame_outputs", 64'(popped), 64'(4 * W * H));
        checkOutput("frame_last_count", 64'(lasts), 64'd1);
    endtask

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid0), 64'd0);
        checkOutput("rst_out_data", 64'(out_data0), 64'd0);
        checkOutput("rst_out_last", 64'(out_last0), 64'd0);
        checkOutput("rst_out_valid_mu", 64'(out_valid1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready0), 64'd1);

        $display("[TB] nearest ramp frame");
        run_frame(0, 1'b0, 1'b0, -1);
        $display("[TB] idx=3 value=5 frame");
        run_frame(1, 1'b0, 1'b0, -1);
        $display("[TB] idx=k mod 4 value=7 frame");
        run_frame(2, 1'b0, 1'b0, -1);
        $display("[TB] ramp frame with backpressure");
        run_frame(0, 1'b1, 1'b1, -1);
        $display("[TB] extremes frame");
        run_frame(3, 1'b0, 1'b0, -1);

        $display("[TB] mid-frame reset after 30 pixels");
        run_frame(0, 1'b0, 1'b0, 30);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(out_valid0), 64'd0);
        checkOutput("async_rst_valid_mu", 64'(out_valid1), 64'd0);
        checkOutput("async_rst_last", 64'(out_last0), 64'd0);
        sb.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1, acc);
        checkOutput("post_rst_in_ready", 64'(in_ready0), 64'd1);
        run_frame(0, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
